// File: rtl/raycast_wall_finder.sv
// raycast_wall_finder: walks a ray's horizontal and vertical grid-line intersections
// against an external tile map and reports the nearest wall hit with its Manhattan distance.
module raycast_wall_finder #(
   parameter int COORD_W    = 12,
   parameter int FRAC_W     = 8,
   parameter int CELL_LOG2  = 6,
   parameter int MAP_W_LOG2 = 4,
   parameter int MAP_H_LOG2 = 4,
   parameter int MAX_STEPS  = 32
) (
   input  logic                             clock,
   input  logic                             resetn,
   input  logic                             start,
   input  logic [1:0]                       mode,
   input  logic [COORD_W-1:0]               player_x,
   input  logic [COORD_W-1:0]               player_y,
   input  logic                             ray_up,
   input  logic                             ray_left,
   input  logic signed [COORD_W+FRAC_W-1:0] h_step_x,
   input  logic signed [COORD_W+FRAC_W-1:0] v_step_y,
   output logic                             map_req,
   output logic [MAP_W_LOG2-1:0]            map_col,
   output logic [MAP_H_LOG2-1:0]            map_row,
   input  logic                             map_ack,
   input  logic                             map_wall,
   output logic                             busy,
   output logic                             done,
   output logic                             wall_found,
   output logic                             hit_vert,
   output logic [COORD_W-1:0]               wall_x,
   output logic [COORD_W-1:0]               wall_y,
   output logic [COORD_W:0]                 hit_dist
);
   localparam int SW = COORD_W + FRAC_W;
   localparam int PW = SW + 2;
   localparam int IW = PW - FRAC_W;
   localparam int MW = PW + CELL_LOG2;
   localparam int CW = $clog2(MAX_STEPS + 1);
   localparam int CELL = 1 << CELL_LOG2;
   localparam logic [PW-1:0] ONE_F = PW'(1) << FRAC_W;
   localparam logic [PW-1:0] CELL_F = PW'(CELL) << FRAC_W;
   localparam logic [CELL_LOG2:0] CELL_C = (CELL_LOG2+1)'(CELL);

   typedef enum logic [3:0] {IDLE, H_INIT, H_STEP, H_REQ, V_INIT, V_STEP, V_REQ, SELECT, DONE} state_t;

   state_t state_q, state_d;
   logic [1:0] mode_q, mode_d;
   logic [COORD_W-1:0] px_q, px_d, py_q, py_d;
   logic up_q, up_d, left_q, left_d;
   logic signed [SW-1:0] hs_q, hs_d, vs_q, vs_d;
   logic [PW-1:0] x_q, x_d, y_q, y_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic hf_q, hf_d, vf_q, vf_d;
   logic [COORD_W-1:0] hx_q, hx_d, hy_q, hy_d, vx_q, vx_d, vy_q, vy_d;
   logic done_q, done_d, found_q, found_d, vert_q, vert_d;
   logic [COORD_W-1:0] wx_q, wx_d, wy_q, wy_d;
   logic [COORD_W:0] dist_q, dist_d;

   logic [IW-1:0] xi, yi;
   logic [CELL_LOG2:0] dy_abs, dx_abs, d_abs;
   logic signed [MW-1:0] d_ext, s_ext, prod;
   logic signed [PW-1:0] off, hs_ext, vs_ext;
   logic [PW-1:0] px_f, py_f, bx_f, by_f;
   logic oob, lim, sel, pick_v, use_h;
   logic [COORD_W:0] h_dist, v_dist;

   function automatic logic [COORD_W-1:0] absd(input logic [COORD_W-1:0] a, input logic [COORD_W-1:0] b);
      return (a > b) ? a - b : b - a;
   endfunction

   assign xi = x_q[PW-1:FRAC_W];
   assign yi = y_q[PW-1:FRAC_W];
   // Distance from the player to the first grid line is (pos mod CELL)+1 going up/left, CELL-(pos mod CELL) otherwise.
   assign dy_abs = up_q ? {1'b0, py_q[CELL_LOG2-1:0]} + (CELL_LOG2+1)'(1) : CELL_C - {1'b0, py_q[CELL_LOG2-1:0]};
   assign dx_abs = left_q ? {1'b0, px_q[CELL_LOG2-1:0]} + (CELL_LOG2+1)'(1) : CELL_C - {1'b0, px_q[CELL_LOG2-1:0]};
   assign d_abs = (state_q == V_INIT) ? dx_abs : dy_abs;
   assign d_ext = {{(MW-CELL_LOG2-1){1'b0}}, d_abs};
   assign s_ext = (state_q == V_INIT) ? MW'(vs_q) : MW'(hs_q);
   assign prod = d_ext * s_ext;
   assign off = PW'(prod >>> CELL_LOG2);
   assign hs_ext = PW'(hs_q);
   assign vs_ext = PW'(vs_q);
   assign px_f = {2'b00, px_q, {FRAC_W{1'b0}}};
   assign py_f = {2'b00, py_q, {FRAC_W{1'b0}}};
   assign bx_f = {2'b00, px_q[COORD_W-1:CELL_LOG2], {(CELL_LOG2+FRAC_W){1'b0}}};
   assign by_f = {2'b00, py_q[COORD_W-1:CELL_LOG2], {(CELL_LOG2+FRAC_W){1'b0}}};
   // Sign bit and any bit above the map extent both mean the point left the map.
   assign oob = ((xi >> (MAP_W_LOG2 + CELL_LOG2)) != '0) || ((yi >> (MAP_H_LOG2 + CELL_LOG2)) != '0);
   assign lim = cnt_q == CW'(MAX_STEPS);
   assign h_dist = (COORD_W+1)'(absd(hx_q, px_q)) + (COORD_W+1)'(absd(hy_q, py_q));
   assign v_dist = (COORD_W+1)'(absd(vx_q, px_q)) + (COORD_W+1)'(absd(vy_q, py_q));
   assign sel = state_q == SELECT;
   assign pick_v = sel && vf_q && (!hf_q || (v_dist < h_dist));
   assign use_h = sel && hf_q && !pick_v;

   always_comb begin
      state_d = state_q;
      mode_d = mode_q;
      px_d = px_q;
      py_d = py_q;
      up_d = up_q;
      left_d = left_q;
      hs_d = hs_q;
      vs_d = vs_q;
      x_d = x_q;
      y_d = y_q;
      cnt_d = cnt_q;
      hf_d = hf_q;
      hx_d = hx_q;
      hy_d = hy_q;
      vf_d = vf_q;
      vx_d = vx_q;
      vy_d = vy_q;
      found_d = found_q;
      vert_d = vert_q;
      wx_d = wx_q;
      wy_d = wy_q;
      dist_d = dist_q;
      done_d = state_q == DONE;
      case (state_q)
         IDLE: if (start) begin
            mode_d = mode;
            px_d = player_x;
            py_d = player_y;
            up_d = ray_up;
            left_d = ray_left;
            hs_d = h_step_x;
            vs_d = v_step_y;
            hf_d = 1'b0;
            vf_d = 1'b0;
            state_d = mode[0] ? H_INIT : mode[1] ? V_INIT : DONE;
         end
         H_INIT: begin
            x_d = px_f + off;
            y_d = up_q ? by_f - ONE_F : by_f + CELL_F;
            cnt_d = '0;
            state_d = H_STEP;
         end
         V_INIT: begin
            x_d = left_q ? bx_f - ONE_F : bx_f + CELL_F;
            y_d = py_f + off;
            cnt_d = '0;
            state_d = V_STEP;
         end
         H_STEP: if (oob || lim) state_d = mode_q[1] ? V_INIT : SELECT;
         else begin
            cnt_d = cnt_q + CW'(1);
            state_d = H_REQ;
         end
         V_STEP: if (oob || lim) state_d = SELECT;
         else begin
            cnt_d = cnt_q + CW'(1);
            state_d = V_REQ;
         end
         H_REQ: if (map_ack) begin
            if (map_wall) begin
               hf_d = 1'b1;
               hx_d = xi[COORD_W-1:0];
               hy_d = yi[COORD_W-1:0];
               state_d = mode_q[1] ? V_INIT : SELECT;
            end else begin
               x_d = x_q + hs_ext;
               y_d = up_q ? y_q - CELL_F : y_q + CELL_F;
               state_d = H_STEP;
            end
         end
         V_REQ: if (map_ack) begin
            if (map_wall) begin
               vf_d = 1'b1;
               vx_d = xi[COORD_W-1:0];
               vy_d = yi[COORD_W-1:0];
               state_d = SELECT;
            end else begin
               x_d = left_q ? x_q - CELL_F : x_q + CELL_F;
               y_d = y_q + vs_ext;
               state_d = V_STEP;
            end
         end
         SELECT: state_d = DONE;
         default: state_d = IDLE;
      endcase
      // Results only change on the way into DONE; arriving straight from IDLE reports no hit.
      if (state_d == DONE && state_q != DONE) begin
         found_d = sel && (hf_q || vf_q);
         vert_d = pick_v;
         wx_d = pick_v ? vx_q : use_h ? hx_q : '0;
         wy_d = pick_v ? vy_q : use_h ? hy_q : '0;
         dist_d = pick_v ? v_dist : use_h ? h_dist : '0;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         mode_q <= '0;
         px_q <= '0;
         py_q <= '0;
         up_q <= 1'b0;
         left_q <= 1'b0;
         hs_q <= '0;
         vs_q <= '0;
         x_q <= '0;
         y_q <= '0;
         cnt_q <= '0;
         hf_q <= 1'b0;
         hx_q <= '0;
         hy_q <= '0;
         vf_q <= 1'b0;
         vx_q <= '0;
         vy_q <= '0;
         done_q <= 1'b0;
         found_q <= 1'b0;
         vert_q <= 1'b0;
         wx_q <= '0;
         wy_q <= '0;
         dist_q <= '0;
      end else begin
         state_q <= state_d;
         mode_q <= mode_d;
         px_q <= px_d;
         py_q <= py_d;
         up_q <= up_d;
         left_q <= left_d;
         hs_q <= hs_d;
         vs_q <= vs_d;
         x_q <= x_d;
         y_q <= y_d;
         cnt_q <= cnt_d;
         hf_q <= hf_d;
         hx_q <= hx_d;
         hy_q <= hy_d;
         vf_q <= vf_d;
         vx_q <= vx_d;
         vy_q <= vy_d;
         done_q <= done_d;
         found_q <= found_d;
         vert_q <= vert_d;
         wx_q <= wx_d;
         wy_q <= wy_d;
         dist_q <= dist_d;
      end
   end

   assign busy = state_q != IDLE;
   assign done = done_q;
   assign map_req = (state_q == H_REQ) || (state_q == V_REQ);
   assign map_col = map_req ? xi[CELL_LOG2 +: MAP_W_LOG2] : '0;
   assign map_row = map_req ? yi[CELL_LOG2 +: MAP_H_LOG2] : '0;
   assign wall_found = found_q;
   assign hit_vert = vert_q;
   assign wall_x = wx_q;
   assign wall_y = wy_q;
   assign hit_dist = dist_q;
endmodule

// File: tb/tb_raycast_wall_finder.sv
// tb_raycast_wall_finder: directed scenarios against a behavioural map responder with
// programmable ack latency; a second instance with MAX_STEPS=4 covers the step limit.
module tb_raycast_wall_finder;
   logic clock = 1'b0;
   logic resetn = 1'b0;
   logic start = 1'b0;
   logic start2 = 1'b0;
   logic [1:0] mode = 2'b00;
   logic [11:0] player_x = '0, player_y = '0;
   logic ray_up = 1'b0, ray_left = 1'b0;
   logic signed [19:0] h_step_x = '0, v_step_y = '0;
   logic map_req, map_ack, map_wall;
   logic [3:0] map_col, map_row;
   logic busy, done, wall_found, hit_vert;
   logic [11:0] wall_x, wall_y;
   logic [12:0] hit_dist;
   logic map_req2, busy2, done2, wf2, hv2;
   logic [3:0] col2, row2;
   logic [11:0] wx2, wy2;
   logic [12:0] hd2;
   bit wmap [16][16];
   int checks = 0, failures = 0;
   int lat = 0, wait_n = 0, n_req = 0, req_cyc = 0, n_done = 0, proto_err = 0;
   int first_row = -1, first_col = -1, last_row = -1, last_col = -1, n_req2 = 0, n_done2 = 0;

   always #5 clock = ~clock;

   raycast_wall_finder dut (
      .clock(clock), .resetn(resetn), .start(start), .mode(mode),
      .player_x(player_x), .player_y(player_y), .ray_up(ray_up), .ray_left(ray_left),
      .h_step_x(h_step_x), .v_step_y(v_step_y), .map_req(map_req), .map_col(map_col),
      .map_row(map_row), .map_ack(map_ack), .map_wall(map_wall), .busy(busy), .done(done),
      .wall_found(wall_found), .hit_vert(hit_vert), .wall_x(wall_x), .wall_y(wall_y),
      .hit_dist(hit_dist)
   );

   raycast_wall_finder #(.MAX_STEPS(4)) dut2 (
      .clock(clock), .resetn(resetn), .start(start2), .mode(mode),
      .player_x(player_x), .player_y(player_y), .ray_up(ray_up), .ray_left(ray_left),
      .h_step_x(h_step_x), .v_step_y(v_step_y), .map_req(map_req2), .map_col(col2),
      .map_row(row2), .map_ack(map_req2), .map_wall(1'b0), .busy(busy2), .done(done2),
      .wall_found(wf2), .hit_vert(hv2), .wall_x(wx2), .wall_y(wy2), .hit_dist(hd2)
   );

   // Map responder: acks after lat idle request cycles, driving inputs between edges.
   initial begin
      map_ack = 1'b0;
      map_wall = 1'b0;
      forever begin
         @(negedge clock);
         if (map_req && map_ack) proto_err++;
         map_ack = 1'b0;
         map_wall = 1'b0;
         if (done) n_done++;
         if (map_req2) n_req2++;
         if (done2) n_done2++;
         if (map_req) begin
            req_cyc++;
            if (wait_n >= lat) begin
               map_ack = 1'b1;
               map_wall = wmap[map_row][map_col];
               n_req++;
               if (n_req == 1) begin first_row = int'(map_row); first_col = int'(map_col); end
               last_row = int'(map_row);
               last_col = int'(map_col);
               wait_n = 0;
            end else wait_n++;
         end else wait_n = 0;
      end
   end

   task automatic setup(input logic [1:0] m, input int px, input int py, input logic up, input logic lf,
                        input int hs, input int vs, input int l);
      @(negedge clock);
      mode = m;
      player_x = 12'(px);
      player_y = 12'(py);
      ray_up = up;
      ray_left = lf;
      h_step_x = 20'(hs);
      v_step_y = 20'(vs);
      lat = l;
      for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) wmap[r][c] = 1'b0;
      n_req = 0; req_cyc = 0; n_done = 0; proto_err = 0;
      first_row = -1; first_col = -1; last_row = -1; last_col = -1;
   endtask

   task automatic cast;
      int cyc;
      @(negedge clock); start = 1'b1;
      @(negedge clock); start = 1'b0;
      cyc = 1;
      while (!done && cyc < 2000) begin @(negedge clock); cyc++; end
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL cast_done done=%b want 1 after %0d cycles", done, cyc); end
   endtask

   task automatic test_reset;
      #12;
      checks++; if ({busy, done, map_req, wall_found, hit_vert} !== 5'b0) begin failures++; $display("FAIL reset_flags got %b want 00000", {busy, done, map_req, wall_found, hit_vert}); end
      checks++; if ({wall_x, wall_y, hit_dist} !== 37'd0) begin failures++; $display("FAIL reset_results got %0d/%0d/%0d want 0", wall_x, wall_y, hit_dist); end
      checks++; if ({map_col, map_row} !== 8'd0) begin failures++; $display("FAIL reset_map_addr got %0d/%0d want 0", map_col, map_row); end
   endtask

   task automatic test_mode00;
      int cyc;
      mode = 2'b00; n_done = 0; req_cyc = 0;
      @(negedge clock); resetn = 1'b1; start = 1'b1;
      @(negedge clock); start = 1'b0;
      cyc = 1;
      while (!done && cyc < 20) begin @(negedge clock); cyc++; end
      checks++; if (cyc != 2) begin failures++; $display("FAIL m00_latency got %0d want 2", cyc); end
      checks++; if (wall_found !== 1'b0) begin failures++; $display("FAIL m00_found got %b want 0", wall_found); end
      @(negedge clock);
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL m00_pulse done=%b want 0", done); end
      checks++; if (req_cyc != 0) begin failures++; $display("FAIL m00_no_req got %0d want 0", req_cyc); end
      checks++; if (n_done != 1) begin failures++; $display("FAIL m00_done_count got %0d want 1", n_done); end
   endtask

   task automatic test_straight_up;
      setup(2'b01, 96, 96, 1'b1, 1'b0, 0, 0, 1);
      wmap[0][1] = 1'b1;
      cast();
      checks++; if ({wall_found, hit_vert} !== 2'b10) begin failures++; $display("FAIL up_flags got %b want 10", {wall_found, hit_vert}); end
      checks++; if (wall_x !== 12'd96 || wall_y !== 12'd63) begin failures++; $display("FAIL up_point got (%0d,%0d) want (96,63)", wall_x, wall_y); end
      checks++; if (hit_dist !== 13'd33) begin failures++; $display("FAIL up_dist got %0d want 33", hit_dist); end
      checks++; if (n_req != 1 || first_col != 1 || first_row != 0) begin failures++; $display("FAIL up_lookup got n=%0d col=%0d row=%0d want 1/1/0", n_req, first_col, first_row); end
      @(negedge clock);
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL up_pulse done=%b want 0", done); end
      checks++; if (proto_err != 0) begin failures++; $display("FAIL up_req_drop got %0d want 0", proto_err); end
   endtask

   task automatic test_escape;
      setup(2'b01, 96, 96, 1'b0, 1'b0, 0, 0, 0);
      cast();
      checks++; if (n_req != 14) begin failures++; $display("FAIL esc_count got %0d want 14", n_req); end
      checks++; if (first_row != 2 || last_row != 15 || last_col != 1) begin failures++; $display("FAIL esc_rows got %0d..%0d col %0d want 2..15 col 1", first_row, last_row, last_col); end
      checks++; if (wall_found !== 1'b0) begin failures++; $display("FAIL esc_found got %b want 0", wall_found); end
      checks++; if ({wall_x, wall_y, hit_dist} !== 37'd0) begin failures++; $display("FAIL esc_zero got %0d/%0d/%0d want 0", wall_x, wall_y, hit_dist); end
   endtask

   task automatic test_nearest;
      setup(2'b11, 96, 96, 1'b1, 1'b0, 16384, -16384, 1);
      wmap[0][2] = 1'b1;
      wmap[1][2] = 1'b1;
      cast();
      checks++; if ({wall_found, hit_vert} !== 2'b11) begin failures++; $display("FAIL near_flags got %b want 11", {wall_found, hit_vert}); end
      checks++; if (wall_x !== 12'd128 || wall_y !== 12'd64) begin failures++; $display("FAIL near_point got (%0d,%0d) want (128,64)", wall_x, wall_y); end
      checks++; if (hit_dist !== 13'd64) begin failures++; $display("FAIL near_dist got %0d want 64", hit_dist); end
      checks++; if (n_req != 2 || first_col != 2 || first_row != 0 || last_row != 1) begin failures++; $display("FAIL near_lookups got n=%0d first=(%0d,%0d) last_row=%0d", n_req, first_col, first_row, last_row); end
   endtask

   task automatic test_tie;
      setup(2'b11, 95, 96, 1'b1, 1'b0, 0, 0, 0);
      wmap[0][1] = 1'b1;
      wmap[1][2] = 1'b1;
      cast();
      checks++; if ({wall_found, hit_vert} !== 2'b10) begin failures++; $display("FAIL tie_flags got %b want 10", {wall_found, hit_vert}); end
      checks++; if (wall_x !== 12'd95 || wall_y !== 12'd63 || hit_dist !== 13'd33) begin failures++; $display("FAIL tie_point got (%0d,%0d) d=%0d want (95,63) d=33", wall_x, wall_y, hit_dist); end
   endtask

   task automatic test_vertical;
      setup(2'b10, 200, 300, 1'b0, 1'b1, 0, 8192, 2);
      wmap[5][1] = 1'b1;
      cast();
      checks++; if ({wall_found, hit_vert} !== 2'b11) begin failures++; $display("FAIL vert_flags got %b want 11", {wall_found, hit_vert}); end
      checks++; if (wall_x !== 12'd127 || wall_y !== 12'd336) begin failures++; $display("FAIL vert_point got (%0d,%0d) want (127,336)", wall_x, wall_y); end
      checks++; if (hit_dist !== 13'd109) begin failures++; $display("FAIL vert_dist got %0d want 109", hit_dist); end
      checks++; if (n_req != 2 || first_col != 2 || first_row != 4) begin failures++; $display("FAIL vert_lookups got n=%0d first=(%0d,%0d) want 2 (2,4)", n_req, first_col, first_row); end
   endtask

   task automatic test_drift_offmap;
      setup(2'b01, 100, 20, 1'b0, 1'b0, -16384, 0, 0);
      cast();
      checks++; if (n_req != 1 || first_col != 0 || first_row != 1) begin failures++; $display("FAIL drift_lookups got n=%0d first=(%0d,%0d) want 1 (0,1)", n_req, first_col, first_row); end
      checks++; if (wall_found !== 1'b0) begin failures++; $display("FAIL drift_found got %b want 0", wall_found); end
   endtask

   task automatic test_reset_mid;
      int cyc;
      setup(2'b01, 96, 96, 1'b1, 1'b0, 0, 0, 5);
      wmap[0][1] = 1'b1;
      @(negedge clock); start = 1'b1;
      @(negedge clock); start = 1'b0;
      cyc = 0;
      while (!map_req && cyc < 50) begin @(negedge clock); cyc++; end
      checks++; if (map_req !== 1'b1) begin failures++; $display("FAIL rmid_req map_req=%b want 1", map_req); end
      @(negedge clock);
      #2 resetn = 1'b0;
      #1;
      checks++; if ({map_req, busy, done} !== 3'b000) begin failures++; $display("FAIL rmid_abort got %b want 000", {map_req, busy, done}); end
      checks++; if (wall_found !== 1'b0 || hit_dist !== 13'd0 || map_col !== 4'd0) begin failures++; $display("FAIL rmid_clear got f=%b d=%0d col=%0d want 0", wall_found, hit_dist, map_col); end
      @(negedge clock); resetn = 1'b1;
      lat = 1;
      n_req = 0;
      cast();
      checks++; if (wall_found !== 1'b1 || wall_x !== 12'd96 || wall_y !== 12'd63 || hit_dist !== 13'd33) begin failures++; $display("FAIL rmid_recast got f=%b (%0d,%0d) d=%0d want 1 (96,63) 33", wall_found, wall_x, wall_y, hit_dist); end
      checks++; if (n_req != 1) begin failures++; $display("FAIL rmid_lookups got %0d want 1", n_req); end
   endtask

   task automatic test_back_to_back;
      setup(2'b01, 96, 96, 1'b0, 1'b0, 0, 0, 0);
      n_req2 = 0;
      n_done2 = 0;
      @(negedge clock); start2 = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         if (done2) break;
      end
      start2 = 1'b0;
      repeat (10) @(negedge clock);
      checks++; if (n_req2 != 4) begin failures++; $display("FAIL limit_checks got %0d want 4", n_req2); end
      checks++; if (n_done2 != 1) begin failures++; $display("FAIL limit_done_count got %0d want 1", n_done2); end
      checks++; if (wf2 !== 1'b0 || busy2 !== 1'b0) begin failures++; $display("FAIL limit_final got found=%b busy=%b want 0/0", wf2, busy2); end
   endtask

   initial begin
      test_reset();
      test_mode00();
      test_straight_up();
      test_escape();
      test_nearest();
      test_tie();
      test_vertical();
      test_drift_offmap();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
